// File: rtl/hex_display_pkg.sv
// Shared constants and hex-to-segment table for the display_hex lab.
package hex_display_pkg;

    localparam logic [0:6] SEG_BLANK  = 7'b1111111;
    localparam logic [3:0] ANODES_OFF = 4'b1111;

    // Active-low cathode patterns, bit 0 = segment a ... bit 6 = segment g.
    function automatic logic [0:6] hex_seg(input logic [3:0] nib);
        logic [0:6] s;
        s = SEG_BLANK;
        unique case (nib)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            4'hF: s = 7'b0111000;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/hex_display_seg7_hex_decode.sv
// Combinational nibble to active-low 7-segment pattern decoder.
module seg7_hex_decode
    import hex_display_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [0:6] seg_o
);

    always_comb begin
        seg_o = hex_seg(nib_i);
    end

endmodule

// File: rtl/hex_display_top.sv
// Four-digit multiplexed hex display driver, SW nibble i on digit i.
// Build option SW_SYNC_EN adds a 2-flop synchronizer on SW.
module hex_display_top
    import hex_display_pkg::*;
#(
    parameter int unsigned DIV_BITS = 17
) (
    input  logic        CLK100MHZ,
    input  logic        reset,
    input  logic [15:0] SW,
    output logic [0:6]  sevenSeg,
    output logic [3:0]  AN
);

    localparam int unsigned CW = DIV_BITS + 2;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    sel;
    logic [15:0]   sw_use;
    logic [3:0]    nib;
    logic [0:6]    seg_dec;
    logic [3:0]    an_q, an_d;
    logic [0:6]    seg_q, seg_d;

`ifdef SW_SYNC_EN
    logic [15:0] sync1_q, sync2_q;

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= SW;
            sync2_q <= sync1_q;
        end
    end

    assign sw_use = sync2_q;
`else
    assign sw_use = SW;
`endif

    assign sel = cnt_q[CW-1 -: 2];
    assign nib = sw_use[{sel, 2'b00} +: 4];

    seg7_hex_decode u_dec (
        .nib_i (nib),
        .seg_o (seg_dec)
    );

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        an_d  = ~(4'b0001 << sel);
        seg_d = seg_dec;
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            cnt_q <= '0;
            an_q  <= ANODES_OFF;
            seg_q <= SEG_BLANK;
        end else begin
            cnt_q <= cnt_d;
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign AN       = an_q;
    assign sevenSeg = seg_q;

endmodule

// File: tb/tb_hex_display_top.sv
// Directed plus random bench for hex_display_top against a scan-position model.
module tb_hex_display_top;

    localparam int DIV = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] sw;
    logic [0:6]  seg;
    logic [3:0]  an;

    int errors = 0;
    int checks = 0;

    logic [6:0] tbl [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // Model: cycles since reset, and SW history for the synchronized build.
    int          n = 0;
    logic [15:0] h1 = '0;
    logic [15:0] h2 = '0;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;

    hex_display_top #(.DIV_BITS(DIV)) dut (
        .CLK100MHZ (clk),
        .reset     (rst),
        .SW        (sw),
        .sevenSeg  (seg),
        .AN        (an)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [6:0] obs,
                       input logic [6:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic model_edge(input logic r, input logic [15:0] s);
        int d;
        logic [15:0] v;
        if (r) begin
            n       = 0;
            h1      = '0;
            h2      = '0;
            exp_an  = 4'b1111;
            exp_seg = 7'b1111111;
        end else begin
            d = (n / (1 << DIV)) % 4;
`ifdef SW_SYNC_EN
            v = h2;
`else
            v = s;
`endif
            exp_an  = 4'b1111 & ~(4'b0001 << d);
            exp_seg = tbl[(v >> (4 * d)) & 16'hF];
            h2 = h1;
            h1 = s;
            n  = n + 1;
        end
    endtask

    task automatic step(input logic r, input logic [15:0] s, input string tag);
        @(negedge clk);
        rst = r;
        sw  = s;
        @(posedge clk);
        model_edge(r, s);
        #1;
        chk({tag, "_an"}, {3'b000, an}, {3'b000, exp_an});
        chk({tag, "_seg"}, seg, exp_seg);
    endtask

    initial begin
        rst = 1'b1;
        sw  = '0;

        for (int i = 0; i < 3; i++) step(1'b1, 16'h0000, "reset");
        chk("reset_const_seg", seg, 7'b1111111);

        step(1'b0, 16'h0000, "first");
        chk("first_const_an", {3'b000, an}, 7'b0001110);

        for (int i = 0; i < 35; i++) step(1'b0, 16'h0F0F, "scan0F0F");

        step(1'b1, 16'h3210, "rst_sweep");
        for (int i = 0; i < 16; i++) step(1'b0, 16'h3210, "sw3210");
        for (int i = 0; i < 16; i++) step(1'b0, 16'h7654, "sw7654");
        for (int i = 0; i < 16; i++) step(1'b0, 16'hBA98, "swBA98");
        for (int i = 0; i < 16; i++) step(1'b0, 16'hFEDC, "swFEDC");

        // Change while digit 0 is lit.
        step(1'b1, 16'h0000, "rst_chg");
        step(1'b0, 16'h0000, "chg_pre");
        step(1'b0, 16'h000A, "chg_post");
`ifndef SW_SYNC_EN
        chk("chg_const_A", seg, 7'b0001000);
`endif
        for (int i = 0; i < 6; i++) step(1'b0, 16'h000A, "chg_hold");

        // Reset mid digit 2.
        step(1'b1, 16'h1234, "rst_mid0");
        for (int i = 0; i < 9; i++) step(1'b0, 16'h1234, "to_dig2");
        step(1'b1, 16'h1234, "rst_mid");
        chk("rst_mid_blank_an", {3'b000, an}, 7'b0001111);
        for (int i = 0; i < 5; i++) step(1'b0, 16'h1234, "after_rst");
        chk("after_rst_dig1", {3'b000, an}, 7'b0001101);

        // Step into digit 0 for the synchronized latency.
        step(1'b1, 16'h0000, "rst_sync");
        step(1'b0, 16'h0000, "sync0");
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0001, "sync1");
`ifdef SW_SYNC_EN
        chk("sync_const_1", seg, 7'b1001111);
`endif

        for (int i = 0; i < 60; i++) begin
            logic [15:0] r16;
            r16 = 16'($urandom);
            for (int k = 0; k < 1 + int'($urandom_range(0, 5)); k++)
                step(1'b0, r16, "random");
        end
        step(1'b1, 16'hFFFF, "rand_rst");
        for (int i = 0; i < 20; i++) step(1'b0, 16'($urandom), "rand2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
